// File: rtl/dmux_route_ctrl_if.sv
// Upstream/downstream beat bus between the route controller and its neighbours.
// The master side drives samples in and accepts routed beats; the slave side is the controller.
interface dmux_route_ctrl_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  sel;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, sel
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, sel
   );
endinterface

// File: rtl/dmux_route_ctrl.sv
// Two-pass batch router: each batch is sent to the statistics path (sel=0),
// then to the normalization path (sel=1), through a single output register.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for start
// STAT      | routing BATCH_SIZE beats to the statistics path
// WAIT_STAT | last statistics beat draining / waiting on stat_done
// NORM      | routing BATCH_SIZE beats to the normalization path
// DRAIN     | waiting for the last normalization beat to leave
// DONE      | batch_done pulse, back to IDLE
module dmux_route_ctrl #(
   parameter int DATA_WIDTH = 16,
   parameter int BATCH_SIZE = 8,
   parameter int CNT_WIDTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stat_done,
   output logic              busy,
   output logic              batch_done,
   dmux_route_ctrl_if.slave  bus
);
   typedef enum logic [2:0] {
      IDLE, STAT, WAIT_STAT, NORM, DRAIN, DONE
   } state_t;

   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BATCH_SIZE - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   state_t                state_q;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic                  out_valid_q;
   logic                  sel_q;
   logic [DATA_WIDTH-1:0] out_data_q;
   logic                  busy_q;
   logic                  batch_done_q;

   logic in_pass;
   logic accept;

   assign in_pass = (state_q == STAT) || (state_q == NORM);
   // Gated by rst_n so nothing is accepted in the cycle a reset is being applied.
   assign bus.in_ready = rst_n && in_pass && (!out_valid_q || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         out_valid_q  <= 1'b0;
         sel_q        <= 1'b0;
         out_data_q   <= '0;
         busy_q       <= 1'b0;
         batch_done_q <= 1'b0;
      end else begin
         batch_done_q <= 1'b0;

         // A new beat overwrites the register even while draining, giving one beat per cycle.
         if (accept) begin
            out_data_q  <= bus.in_data;
            sel_q       <= (state_q == NORM);
            out_valid_q <= 1'b1;
         end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= STAT;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            STAT, NORM: begin
               if (accept) begin
                  if (cnt_q == LAST_CNT) begin
                     cnt_q   <= '0;
                     state_q <= (state_q == STAT) ? WAIT_STAT : DRAIN;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
            end
            WAIT_STAT: begin
               if (stat_done && !out_valid_q) state_q <= NORM;
            end
            DRAIN: begin
               if (!out_valid_q) begin
                  state_q      <= DONE;
                  batch_done_q <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.sel       = sel_q;
   assign busy          = busy_q;
   assign batch_done    = batch_done_q;
endmodule
